// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time tester: FSM states,
// LFSR seed/taps and the "no best time recorded" marker.
package reaction_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_MEASURE,
        ST_SHOW
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16/14/13/11 expressed as bit positions 15/13/12/10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] NO_BEST   = 16'hFFFF;

    function automatic logic [15:0] lfsr_step(input logic [15:0] value);
        return {value[14:0], ^(value & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick divider; restart re-phases it so the first tick lands
// exactly one millisecond after the restart cycle.
module ms_tick_gen #(
    parameter int unsigned CLKS_PER_MS = 50_000
) (
    input  logic clk,
    input  logic rstn,
    input  logic restart,
    output logic tick
);

    localparam int unsigned W = $clog2(CLKS_PER_MS);
    localparam logic [W-1:0] DIV_MAX = W'(CLKS_PER_MS - 1);

    logic [W-1:0] div;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div <= '0;
        end else if (restart || div == DIV_MAX) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    assign tick = (div == DIV_MAX);

endmodule

// File: rtl/reaction_test_ctrl.sv
// Reaction-time tester: random pre-stimulus delay, stimulus LED, response
// timing in ms with false-start / timeout detection and a best-time record.
module reaction_test_ctrl
    import reaction_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned MIN_DELAY_MS = 1000,
    parameter int unsigned TIMEOUT_MS   = 9999
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        resp,
    input  logic        clear_best,
    output logic        led_stim,
    output logic        busy,
    output logic [15:0] result_ms,
    output logic        result_valid,
    output logic        early,
    output logic        timeout,
    output logic [15:0] best_ms
);

    localparam logic [15:0] MIN_DELAY = 16'(MIN_DELAY_MS);
    localparam logic [15:0] TIMEOUT   = 16'(TIMEOUT_MS);

    state_t      state_q, state_d;
    logic [15:0] lfsr_q;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] target_q, target_d;
    logic [15:0] result_d, best_d;
    logic        valid_d, early_d, timeout_d;
    logic [15:0] cnt_inc, tick_cnt;
    logic        tick, restart;

    ms_tick_gen #(.CLKS_PER_MS(CLK_HZ / 1000)) u_tick (
        .clk     (clk),
        .rstn    (rstn),
        .restart (restart),
        .tick    (tick)
    );

    // Saturating increment; tick_cnt is the count as seen after this cycle's tick.
    assign cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign tick_cnt = tick ? cnt_inc : cnt_q;
    assign restart  = (state_d != state_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            lfsr_q       <= LFSR_SEED;
            cnt_q        <= '0;
            target_q     <= '0;
            result_ms    <= '0;
            result_valid <= 1'b0;
            early        <= 1'b0;
            timeout      <= 1'b0;
            best_ms      <= NO_BEST;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_step(lfsr_q);
            cnt_q        <= cnt_d;
            target_q     <= target_d;
            result_ms    <= result_d;
            result_valid <= valid_d;
            early        <= early_d;
            timeout      <= timeout_d;
            best_ms      <= best_d;
        end
    end

    // NOTE: every signal gets a hold default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        target_d  = target_q;
        result_d  = result_ms;
        valid_d   = result_valid;
        early_d   = early;
        timeout_d = timeout;
        best_d    = best_ms;

        case (state_q)
            ST_IDLE, ST_SHOW: begin
                if (start) begin
                    state_d   = ST_DELAY;
                    target_d  = MIN_DELAY + {5'd0, lfsr_q[10:0]};
                    cnt_d     = '0;
                    valid_d   = 1'b0;
                    early_d   = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            ST_DELAY: begin
                if (resp) begin
                    state_d  = ST_SHOW;
                    early_d  = 1'b1;
                    result_d = '0;
                end else if (tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == target_q) begin
                        state_d = ST_MEASURE;
                        cnt_d   = '0;
                    end
                end
            end
            ST_MEASURE: begin
                // A response on the timeout tick still counts as valid.
                if (resp) begin
                    state_d  = ST_SHOW;
                    result_d = tick_cnt;
                    valid_d  = 1'b1;
                    if (tick_cnt < best_ms) best_d = tick_cnt;
                end else if (tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TIMEOUT) begin
                        state_d   = ST_SHOW;
                        timeout_d = 1'b1;
                        result_d  = TIMEOUT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (clear_best) best_d = NO_BEST;
    end

    assign led_stim = (state_q == ST_MEASURE);
    assign busy     = (state_q == ST_DELAY) || (state_q == ST_MEASURE);

endmodule

// File: tb/tb_reaction_test_ctrl.sv
// Directed bench for reaction_test_ctrl at 4 clocks/ms, 2 ms minimum delay
// and a 20 ms timeout; all inputs change on the falling clock edge.
module tb_reaction_test_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        start = 1'b0;
    logic        resp = 1'b0;
    logic        clear_best = 1'b0;
    logic        led_stim, busy, result_valid, early, timeout;
    logic [15:0] result_ms, best_ms;
    logic [15:0] lfsr_m;

    int checks = 0;
    int failures = 0;
    int first_delay = 0;

    reaction_test_ctrl #(
        .CLK_HZ       (4000),
        .MIN_DELAY_MS (2),
        .TIMEOUT_MS   (20)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .resp         (resp),
        .clear_best   (clear_best),
        .led_stim     (led_stim),
        .busy         (busy),
        .result_ms    (result_ms),
        .result_valid (result_valid),
        .early        (early),
        .timeout      (timeout),
        .best_ms      (best_ms)
    );

    always #5 clk = ~clk;

    // Reference LFSR: taps 16/14/13/11, seed ACE1, one step per clock.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) lfsr_m <= 16'hACE1;
        else       lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    // Pulse start for one cycle; exp_n is the falling-edge count (start edge = 0)
    // at which led_stim should first be seen high.
    task automatic pulse_start(output int exp_n);
        @(negedge clk);
        exp_n = 4 * (2 + int'(lfsr_m[10:0])) + 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count falling edges until led_stim is high; optionally pulse start at count inj.
    task automatic wait_stim(input int inj, output int n);
        n = 1;
        while (!led_stim && n < 12000) begin
            start = (n == inj);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
    endtask

    // Respond so that resp is sampled e rising edges after the current falling edge.
    task automatic resp_at(input int e);
        repeat (e - 1) @(negedge clk);
        resp = 1'b1;
        @(negedge clk);
        resp = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        #3 rstn = 1'b0;
        #20;
        checks++;
        if ({led_stim, busy, result_valid, early, timeout} !== 5'b0 || result_ms !== 16'd0) begin
            failures++;
            $display("FAIL reset_flags: got led=%b busy=%b valid=%b early=%b timeout=%b result=%0d expected all 0",
                     led_stim, busy, result_valid, early, timeout, result_ms);
        end
        checks++;
        if (best_ms !== 16'hFFFF) begin
            failures++;
            $display("FAIL reset_best: got %h expected ffff", best_ms);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_basic();
        int exp_n, n;
        repeat (2) @(negedge clk);
        pulse_start(exp_n);
        checks++;
        if (busy !== 1'b1 || led_stim !== 1'b0) begin
            failures++;
            $display("FAIL basic_delay_state: got busy=%b led=%b expected busy=1 led=0", busy, led_stim);
        end
        wait_stim(0, n);
        first_delay = n;
        checks++;
        if (n !== exp_n) begin
            failures++;
            $display("FAIL basic_delay_len: got %0d expected %0d", n, exp_n);
        end
        resp_at(20);
        checks++;
        if (result_ms !== 16'd5 || result_valid !== 1'b1 || best_ms !== 16'd5) begin
            failures++;
            $display("FAIL basic_result: got result=%0d valid=%b best=%0d expected 5 1 5",
                     result_ms, result_valid, best_ms);
        end
        checks++;
        if (led_stim !== 1'b0 || busy !== 1'b0 || early !== 1'b0 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL basic_show: got led=%b busy=%b early=%b timeout=%b expected 0 0 0 0",
                     led_stim, busy, early, timeout);
        end
    endtask

    task automatic test_early();
        int  exp_n;
        logic saw_led = 1'b0;
        pulse_start(exp_n);
        repeat (2) begin
            @(negedge clk);
            if (led_stim) saw_led = 1'b1;
        end
        resp = 1'b1;
        @(negedge clk);
        resp = 1'b0;
        repeat (20) begin
            if (led_stim) saw_led = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (early !== 1'b1 || result_ms !== 16'd0 || result_valid !== 1'b0 || best_ms !== 16'd5) begin
            failures++;
            $display("FAIL early_result: got early=%b result=%0d valid=%b best=%0d expected 1 0 0 5",
                     early, result_ms, result_valid, best_ms);
        end
        checks++;
        if (saw_led !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL early_led: got saw_led=%b busy=%b expected 0 0", saw_led, busy);
        end
    endtask

    task automatic test_timeout();
        int exp_n, n, t;
        pulse_start(exp_n);
        wait_stim(0, n);
        t = 0;
        while (!timeout && t < 200) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t !== 80) begin
            failures++;
            $display("FAIL timeout_latency: got %0d cycles expected 80", t);
        end
        checks++;
        if (result_ms !== 16'd20 || result_valid !== 1'b0 || led_stim !== 1'b0 || best_ms !== 16'd5) begin
            failures++;
            $display("FAIL timeout_result: got result=%0d valid=%b led=%b best=%0d expected 20 0 0 5",
                     result_ms, result_valid, led_stim, best_ms);
        end
    endtask

    task automatic test_resp_on_timeout();
        int exp_n, n;
        pulse_start(exp_n);
        wait_stim(0, n);
        resp_at(80);
        checks++;
        if (result_ms !== 16'd20 || result_valid !== 1'b1 || timeout !== 1'b0 || best_ms !== 16'd5) begin
            failures++;
            $display("FAIL resp_on_timeout: got result=%0d valid=%b timeout=%b best=%0d expected 20 1 0 5",
                     result_ms, result_valid, timeout, best_ms);
        end
    endtask

    task automatic test_start_ignored();
        int exp_n, n;
        pulse_start(exp_n);
        wait_stim(5, n);
        checks++;
        if (n !== exp_n) begin
            failures++;
            $display("FAIL start_in_delay: got delay %0d expected %0d", n, exp_n);
        end
        repeat (9) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (led_stim !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL start_in_measure_state: got led=%b busy=%b expected 1 1", led_stim, busy);
        end
        resp_at(14);
        checks++;
        if (result_ms !== 16'd6 || result_valid !== 1'b1 || best_ms !== 16'd5) begin
            failures++;
            $display("FAIL start_in_measure_result: got result=%0d valid=%b best=%0d expected 6 1 5",
                     result_ms, result_valid, best_ms);
        end
    endtask

    task automatic test_best();
        int exp_n, n;
        int ms_tab[3]   = '{7, 3, 9};
        int best_tab[3] = '{7, 3, 3};
        @(negedge clk);
        clear_best = 1'b1;
        @(negedge clk);
        clear_best = 1'b0;
        checks++;
        if (best_ms !== 16'hFFFF) begin
            failures++;
            $display("FAIL best_clear_initial: got %h expected ffff", best_ms);
        end
        for (int i = 0; i < 3; i++) begin
            pulse_start(exp_n);
            wait_stim(0, n);
            resp_at(4 * ms_tab[i]);
            checks++;
            if (result_ms !== 16'(ms_tab[i]) || best_ms !== 16'(best_tab[i])) begin
                failures++;
                $display("FAIL best_trial%0d: got result=%0d best=%0d expected %0d %0d",
                         i, result_ms, best_ms, ms_tab[i], best_tab[i]);
            end
        end
        clear_best = 1'b1;
        @(negedge clk);
        clear_best = 1'b0;
        checks++;
        if (best_ms !== 16'hFFFF) begin
            failures++;
            $display("FAIL best_clear: got %h expected ffff", best_ms);
        end
        pulse_start(exp_n);
        wait_stim(0, n);
        repeat (15) @(negedge clk);
        resp = 1'b1;
        clear_best = 1'b1;
        @(negedge clk);
        resp = 1'b0;
        clear_best = 1'b0;
        checks++;
        if (best_ms !== 16'hFFFF || result_ms !== 16'd4 || result_valid !== 1'b1) begin
            failures++;
            $display("FAIL best_clear_wins: got best=%h result=%0d valid=%b expected ffff 4 1",
                     best_ms, result_ms, result_valid);
        end
    endtask

    task automatic test_reset_mid();
        int exp_n, n;
        pulse_start(exp_n);
        wait_stim(0, n);
        repeat (6) @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        checks++;
        if ({led_stim, busy, result_valid, early, timeout} !== 5'b0 || result_ms !== 16'd0 ||
            best_ms !== 16'hFFFF) begin
            failures++;
            $display("FAIL reset_mid: got led=%b busy=%b valid=%b early=%b timeout=%b result=%0d best=%h expected reset values",
                     led_stim, busy, result_valid, early, timeout, result_ms, best_ms);
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        pulse_start(exp_n);
        wait_stim(0, n);
        checks++;
        if (n !== first_delay) begin
            failures++;
            $display("FAIL reset_mid_delay: got %0d expected %0d", n, first_delay);
        end
        resp_at(20);
        checks++;
        if (result_ms !== 16'd5 || result_valid !== 1'b1 || best_ms !== 16'd5) begin
            failures++;
            $display("FAIL reset_mid_result: got result=%0d valid=%b best=%0d expected 5 1 5",
                     result_ms, result_valid, best_ms);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_early();
        test_timeout();
        test_resp_on_timeout();
        test_start_ignored();
        test_best();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
